out_drain_scheduler: RTL and testbench
======================================

Name: out_drain_scheduler

Overview:
- Sequences write-back of 8x8 matrix-multiply result tiles into the 64-entry output buffer.
- After a start pulse, waits out the array fill latency, then issues 8 write beats per tile. Each beat drives 8 lanes of 6-bit diagonal addresses.
- Handles downstream back-pressure and runs multiple tiles back-to-back.
- Sits between the top-level compute controller and the output buffer write port.

Parameters:
- DATA_BW, 8, lane data width; only used for the lane count/width checks in the package.
- ADDR_SIZE, 6, per-lane address width ({row 3b, col 3b}).
- FILL_LAT, 15, cycles from start acceptance to the first write beat; 0 is legal.
- TILE_CW, 4, width of the tile count input.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- num_tiles  in  TILE_CW  number of tiles to drain; latched on accepted start.
- wr_ready  in  1  output buffer can accept the current beat.
- wr_en  out  8  per-lane write strobes.
- wr_addr  out  8*ADDR_SIZE  lane i address at [ADDR_SIZE*i +: ADDR_SIZE].
- tile_idx  out  TILE_CW  index of the tile being drained.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last beat of the last tile is accepted.

Behaviour:
- Reset (and rst asserted in any state, mid-operation included) forces the following on the next edge:
  - state=IDLE;
  - wr_en=0, busy=0, done=0, tile_idx=0;
  - fill counter, beat counter and tile counter = 0;
  - wr_addr = base pattern.
- Base pattern: lane i = {(8-i) mod 8, 7-i}.
  - Lane0=0x07, lane1=0x3E, lane7=0x08.
- Address generator stepping:
  - Each accepted beat: lane i row field <= lane (i-1 mod 8) row field; col field fixed at 7-i.
  - So beat b gives lane i = {(8-i+b) mod 8, 7-i}.
  - The generator reloads the base pattern at the start of every tile.
- FSM states: IDLE, FILL, RUN, DONE.
- IDLE:
  - start=1 and num_tiles!=0 -> latch num_tiles, tile_idx=0, reload generator.
  - Then go to FILL, or directly to RUN if FILL_LAT=0.
  - start with num_tiles=0 is ignored; no busy, no done.
- FILL:
  - Counts FILL_LAT cycles; wr_en=0.
  - Exits to RUN after exactly FILL_LAT cycles in FILL.
  - First beat is presented FILL_LAT+1 cycles after the start edge.
- RUN:
  - wr_en=8'hFF every cycle; wr_addr = generator output.
  - A beat is accepted when wr_ready=1. Only then does the generator step and the beat counter increment.
  - wr_ready=0: wr_en, wr_addr and counters hold unchanged; stall duration is unbounded.
  - Accepted beat 7, more tiles remaining: tile_idx+1, reload generator, stay in RUN. The next cycle presents beat 0 of the new tile (no refill gap).
  - Accepted beat 7 of the last tile: go to DONE.
- DONE:
  - done=1 and busy=1 for one cycle, wr_en=0.
  - Next cycle returns to IDLE.
  - start during DONE is ignored.
- start while busy is ignored in all non-IDLE states.
- Counter widths:
  - fill counter: clog2(FILL_LAT+1) bits;
  - beat counter: 3 bits, natural wrap 7->0;
  - tile counter: TILE_CW bits.
  - No arithmetic overflow is possible.
- All outputs are registered.

Decomposition:
- Package out_drain_pkg holds:
  - state encoding constants (IDLE=2'd0, FILL=2'd1, RUN=2'd2, DONE=2'd3);
  - NUM_LANES=8, BEATS_PER_TILE=8;
  - the base-pattern lane constants.
- One sub-module, diag_addr_gen:
  - 8-lane circular row-field shifter with synchronous load (reload) and step (enable).
  - Contains only clk, rst, load, step and addr bus.
  - The FSM and counters stay in the top module.

Test Plan:
- Single tile, FILL_LAT=15, wr_ready=1:
  - start at cycle 0 -> busy from cycle 1.
  - wr_en=FF for cycles 16..23; beat0 lane0=0x07, lane7=0x08; beat1 lane0=0x0F, lane7=0x10; beat2 lane3=0x3C.
  - done pulse at cycle 24; busy=0 at cycle 25.
- Back-pressure:
  - wr_ready=0 during beats 3 and 5 for 4 cycles each -> wr_addr frozen at beat 3/5 values, wr_en stays FF.
  - Total RUN length 16 cycles; 8 distinct address sets in order.
- Multi-tile, num_tiles=3:
  - 24 contiguous beats; tile_idx 0,1,2.
  - Address pattern restarts at lane0=0x07 on beats 8 and 16; a single done after beat 23.
- Ignored starts:
  - start with num_tiles=0 -> busy stays 0, no done.
  - start re-pulsed during FILL and RUN -> no effect on beat count or timing.
- Reset mid-RUN:
  - rst=1 at beat 4 -> next edge: wr_en=0, busy=0, wr_addr=base pattern, no done.
  - A new start then produces a normal full tile.
- FILL_LAT=0 build: start at cycle 0 -> first beat (lane0=0x07) presented at cycle 1.

Source files
------------

// File: rtl/out_drain_scheduler_pkg.sv
// Shared constants for the output-buffer drain scheduler.
// Holds the FSM state encoding, lane/beat geometry and the per-lane base
// address pattern: lane i = {row (8-i) mod 8, col 7-i}.
package out_drain_pkg;

    localparam int LANE_DATA_W    = 8;
    localparam int LANE_ADDR_W    = 6;
    localparam int ROW_W          = 3;
    localparam int COL_W          = 3;
    localparam int NUM_LANES      = 8;
    localparam int BEATS_PER_TILE = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Lane 7 in the top slice, lane 0 in the bottom slice.
    localparam logic [NUM_LANES*LANE_ADDR_W-1:0] BASE_PATTERN = {
        6'h08, 6'h11, 6'h1A, 6'h23, 6'h2C, 6'h35, 6'h3E, 6'h07
    };

    // One lane per data byte, and row+col must exactly fill a lane address.
    localparam bit LANE_CFG_OK = (NUM_LANES == LANE_DATA_W) &&
                                 (ROW_W + COL_W == LANE_ADDR_W);

    function automatic logic [ROW_W-1:0] base_row(input int lane);
        return BASE_PATTERN[lane*LANE_ADDR_W + COL_W +: ROW_W];
    endfunction

    function automatic logic [COL_W-1:0] base_col(input int lane);
        return BASE_PATTERN[lane*LANE_ADDR_W +: COL_W];
    endfunction

endpackage

// File: rtl/out_drain_scheduler_if.sv
// Handshake/bus bundle between the compute controller, the drain scheduler
// and the output-buffer write port.
//   start, num_tiles : request from controller
//   wr_ready         : output buffer accepts the current beat
//   wr_en, wr_addr   : per-lane strobes and addresses
//   tile_idx, busy, done : status back to controller
// master = requesting/testing side, slave = scheduler.
interface out_drain_scheduler_if
    import out_drain_pkg::*;
#(
    parameter int ADDR_SIZE = 6,
    parameter int TILE_CW   = 4
) ();

    logic                           start;
    logic [TILE_CW-1:0]             num_tiles;
    logic                           wr_ready;
    logic [NUM_LANES-1:0]           wr_en;
    logic [NUM_LANES*ADDR_SIZE-1:0] wr_addr;
    logic [TILE_CW-1:0]             tile_idx;
    logic                           busy;
    logic                           done;

    modport master (
        output start, num_tiles, wr_ready,
        input  wr_en, wr_addr, tile_idx, busy, done
    );

    modport slave (
        input  start, num_tiles, wr_ready,
        output wr_en, wr_addr, tile_idx, busy, done
    );

endinterface

// File: rtl/out_drain_scheduler_diag_addr_gen.sv
// Diagonal address generator: 8 lanes whose row fields rotate one lane up on
// every step, column fields fixed at 7-i.
//   clk, rst : clock, synchronous active-high reset (loads base pattern)
//   load     : reload base pattern (has priority over step)
//   step     : rotate row fields, lane i takes lane (i-1 mod 8)
//   addr     : lane i address at [ADDR_SIZE*i +: ADDR_SIZE]
module diag_addr_gen
    import out_drain_pkg::*;
#(
    parameter int ADDR_SIZE = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic                           step,
    output logic [NUM_LANES*ADDR_SIZE-1:0] addr
);

    logic [ROW_W-1:0] row_q [NUM_LANES];
    logic [ROW_W-1:0] row_d [NUM_LANES];

    // Next row fields: reload, rotate, or hold.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (load) begin
                row_d[i] = base_row(i);
            end else if (step) begin
                row_d[i] = row_q[(i + NUM_LANES - 1) % NUM_LANES];
            end else begin
                row_d[i] = row_q[i];
            end
        end
    end

    // Row field registers; reset restores the base pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                row_q[i] <= base_row(i);
            end
        end else begin
            row_q <= row_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign addr[g*ADDR_SIZE +: ADDR_SIZE] = ADDR_SIZE'({row_q[g], base_col(g)});
    end

endmodule

// File: rtl/out_drain_scheduler.sv
// Output drain scheduler: after an accepted start, waits FILL_LAT cycles for
// the array to fill, then writes 8 beats per tile (8 lanes each) into the
// output buffer, honouring wr_ready back-pressure, for num_tiles tiles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of out_drain_scheduler_if (start/num_tiles/wr_ready
//              in; wr_en/wr_addr/tile_idx/busy/done out, all registered)
module out_drain_scheduler
    import out_drain_pkg::*;
#(
    parameter int ADDR_SIZE = 6,
    parameter int FILL_LAT  = 15,
    parameter int TILE_CW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    out_drain_scheduler_if.slave  bus
);

    // A zero-latency build still needs a 1-bit counter to keep widths legal.
    localparam int FILL_CW = (FILL_LAT > 0) ? $clog2(FILL_LAT + 1) : 1;
    localparam logic [FILL_CW-1:0] FILL_LAST = FILL_CW'((FILL_LAT > 0) ? FILL_LAT - 1 : 0);

    logic [1:0]               state_q,  state_d;
    logic [FILL_CW-1:0]       fill_q,   fill_d;
    logic [2:0]               beat_q,   beat_d;
    logic [TILE_CW-1:0]       tile_q,   tile_d;
    logic [TILE_CW-1:0]       ntiles_q, ntiles_d;
    logic [NUM_LANES-1:0]     wr_en_q,  wr_en_d;
    logic                     busy_q,   busy_d;
    logic                     done_q,   done_d;
    logic                     load_s;
    logic                     step_s;
    logic [NUM_LANES*ADDR_SIZE-1:0] addr_s;

    diag_addr_gen #(.ADDR_SIZE(ADDR_SIZE)) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .step (step_s),
        .addr (addr_s)
    );

    // FSM next state, counters and generator control.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        beat_d   = beat_q;
        tile_d   = tile_q;
        ntiles_d = ntiles_q;
        load_s   = 1'b0;
        step_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.num_tiles != {TILE_CW{1'b0}})) begin
                    ntiles_d = bus.num_tiles;
                    tile_d   = {TILE_CW{1'b0}};
                    fill_d   = {FILL_CW{1'b0}};
                    beat_d   = 3'd0;
                    load_s   = 1'b1;
                    state_d  = (FILL_LAT == 0) ? ST_RUN : ST_FILL;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_q == FILL_LAST) begin
                    fill_d  = {FILL_CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    fill_d  = fill_q + FILL_CW'(1);
                end
            end
            ST_RUN: begin
                if (bus.wr_ready) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'(BEATS_PER_TILE - 1)) begin
                        // Tile boundary: restart the diagonal pattern either way.
                        load_s = 1'b1;
                        if (tile_q + TILE_CW'(1) == ntiles_q) begin
                            state_d = ST_DONE;
                        end else begin
                            tile_d  = tile_q + TILE_CW'(1);
                        end
                    end else begin
                        step_s = 1'b1;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        wr_en_d = (state_d == ST_RUN) ? {NUM_LANES{1'b1}} : {NUM_LANES{1'b0}};
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            fill_q   <= {FILL_CW{1'b0}};
            beat_q   <= 3'd0;
            tile_q   <= {TILE_CW{1'b0}};
            ntiles_q <= {TILE_CW{1'b0}};
            wr_en_q  <= {NUM_LANES{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            beat_q   <= beat_d;
            tile_q   <= tile_d;
            ntiles_q <= ntiles_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = addr_s;
    assign bus.tile_idx = tile_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_out_drain_scheduler.sv
module tb_out_drain_scheduler;
    import out_drain_pkg::*;

    localparam logic [47:0] BASE_EXP = {6'h08, 6'h11, 6'h1A, 6'h23, 6'h2C, 6'h35, 6'h3E, 6'h07};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    out_drain_scheduler_if #(.ADDR_SIZE(6), .TILE_CW(4)) bus  ();
    out_drain_scheduler_if #(.ADDR_SIZE(6), .TILE_CW(4)) bus0 ();

    out_drain_scheduler #(.ADDR_SIZE(6), .FILL_LAT(15), .TILE_CW(4)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    out_drain_scheduler #(.ADDR_SIZE(6), .FILL_LAT(0), .TILE_CW(4)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    typedef struct packed {
        logic [47:0] addr;
        logic [3:0]  tile;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   done_pending = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Beat b of a tile: lane i = {(8-i+b) mod 8, 7-i}
    function automatic logic [47:0] exp_addr(input int b);
        logic [47:0] a;
        for (int i = 0; i < 8; i++) begin
            a[6*i +: 6] = {3'((8 - i + b) % 8), 3'(7 - i)};
        end
        return a;
    endfunction

    task automatic push_tile(input int t);
        exp_t x;
        for (int b = 0; b < 8; b++) begin
            x.addr = exp_addr(b);
            x.tile = 4'(t);
            exp_q.push_back(x);
        end
    endtask

    // Monitor: every accepted beat and every done pulse is matched to the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.wr_en == 8'hFF && bus.wr_ready) begin
            check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("beat_addr", bus.wr_addr, mon_e.addr);
                check("beat_tile", bus.tile_idx, mon_e.tile);
            end
        end
        if (!rst && bus.done) begin
            check("done_expected", 64'(done_pending > 0), 64'd1);
            if (done_pending > 0) done_pending--;
        end
    end

    // Caller is just after a posedge: this cycle is cycle 0.
    task automatic timed_run(input int n, input bit extra);
        int last;
        last = 16 + 8 * n;
        bus.start = 1'b1;
        bus.num_tiles = 4'(n);
        for (int t = 0; t < n; t++) push_tile(t);
        done_pending++;
        for (int c = 1; c <= last + 2; c++) begin
            @(posedge clk); #1;
            if (extra && (c == 5 || c == 20 || c == last)) begin
                bus.start = 1'b1;
                bus.num_tiles = 4'd7;
            end else begin
                bus.start = 1'b0;
                bus.num_tiles = 4'(n);
            end
            @(negedge clk);
            check("busy", bus.busy, 64'(c >= 1 && c <= last));
            check("wr_en", bus.wr_en, (c >= 16 && c < last) ? 64'hFF : 64'h00);
            check("done", bus.done, 64'(c == last));
            if (c >= 16 && c < last) check("tile_idx", bus.tile_idx, 64'((c - 16) / 8));
            if (c == 16) begin
                check("b0_lane0", bus.wr_addr[5:0], 64'h07);
                check("b0_lane7", bus.wr_addr[47:42], 64'h08);
            end
            if (c == 17) begin
                check("b1_lane0", bus.wr_addr[5:0], 64'h0F);
                check("b1_lane7", bus.wr_addr[47:42], 64'h10);
            end
            if (c == 18) check("b2_lane3", bus.wr_addr[23:18], 64'h3C);
            if ((c == 24 || c == 32) && c < last) check("tile_restart_lane0", bus.wr_addr[5:0], 64'h07);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bit found;
        int be;
        rst = 1'b1;
        bus.start = 1'b0;  bus.num_tiles = 4'd0;  bus.wr_ready = 1'b1;
        bus0.start = 1'b0; bus0.num_tiles = 4'd0; bus0.wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", bus.wr_en, 64'h00);
        check("rst_busy", bus.busy, 64'd0);
        check("rst_done", bus.done, 64'd0);
        check("rst_tile", bus.tile_idx, 64'd0);
        check("rst_addr", bus.wr_addr, BASE_EXP);
        check("rst_addr_f0", bus0.wr_addr, BASE_EXP);
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero fill latency build: first beat one cycle after start.
        @(posedge clk); #1;
        bus0.start = 1'b1; bus0.num_tiles = 4'd1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            bus0.start = 1'b0;
            @(negedge clk);
            check("f0_wr_en", bus0.wr_en, (c >= 1 && c <= 8) ? 64'hFF : 64'h00);
            check("f0_done", bus0.done, 64'(c == 9));
            if (c == 1) check("f0_b0_lane0", bus0.wr_addr[5:0], 64'h07);
            if (c == 2) check("f0_b1_lane0", bus0.wr_addr[5:0], 64'h0F);
        end

        // Single tile, full timing.
        @(posedge clk); #1;
        timed_run(1, 1'b0);

        // Start with zero tiles is ignored.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_tiles = 4'd0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            check("zero_busy", bus.busy, 64'd0);
            check("zero_done", bus.done, 64'd0);
        end

        // Back-pressure: 4-cycle stalls on beats 3 and 5.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_tiles = 4'd1;
        push_tile(0);
        done_pending++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus.wr_en == 8'hFF) found = 1'b1;
        end
        check("bp_first_beat_seen", 64'(found), 64'd1);
        if (found) begin
            for (int r = 0; r < 16; r++) begin
                be = (r < 3) ? r : (r <= 7) ? 3 : (r == 8) ? 4 : (r <= 13) ? 5 : r - 8;
                check("bp_wr_en", bus.wr_en, 64'hFF);
                check("bp_addr", bus.wr_addr, exp_addr(be));
                @(posedge clk); #1;
                bus.wr_ready = !(((r + 1) >= 3 && (r + 1) <= 6) || ((r + 1) >= 9 && (r + 1) <= 12));
            end
            @(negedge clk);
            check("bp_done", bus.done, 64'd1);
            check("bp_wr_en_off", bus.wr_en, 64'h00);
        end
        bus.wr_ready = 1'b1;

        // Three tiles back-to-back, with ignored starts in FILL, RUN and DONE.
        @(posedge clk); #1;
        timed_run(3, 1'b1);

        // Reset while beat 4 is presented.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_tiles = 4'd1;
        push_tile(0);
        done_pending++;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_wr_en", bus.wr_en, 64'h00);
        check("mid_rst_busy", bus.busy, 64'd0);
        check("mid_rst_done", bus.done, 64'd0);
        check("mid_rst_addr", bus.wr_addr, BASE_EXP);
        check("mid_rst_tile", bus.tile_idx, 64'd0);
        check("mid_rst_beats_left", 64'(exp_q.size()), 64'd4);
        exp_q.delete();
        done_pending = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        timed_run(1, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        check("end_done_pending", 64'(done_pending), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
